// File: rtl/mprj_checkpoint_monitor.sv
// mprj_checkpoint_monitor
// Ordered checkpoint sequencer: waits for NUM_CKPT programmed values to
// appear on watch_in in order, each stable for STABLE cycles, with a
// per-stage timeout. Reports sticky pass/fail and the awaited stage.
module mprj_checkpoint_monitor #(
    parameter int WIDTH     = 16,
    parameter int NUM_CKPT  = 4,
    parameter int STABLE    = 2,
    parameter int TIMEOUT_W = 24,
    parameter int IDX_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                      clock,
    input  logic                      resetb,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_CKPT*WIDTH-1:0] cfg_ckpt,
    input  logic [TIMEOUT_W-1:0]      cfg_timeout,
    input  logic [WIDTH-1:0]          watch_in,
    output logic                      busy,
    output logic                      hit,
    output logic [IDX_W-1:0]          stage,
    output logic                      pass,
    output logic                      fail,
    output logic [1:0]                fail_code
);

    localparam int MC_W = $clog2(STABLE + 1);
    localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(STABLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CKPT - 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_ABORT   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       stage_q, stage_d;
    logic [MC_W-1:0]        match_cnt_q, match_cnt_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   busy_q, busy_d;
    logic                   hit_q, hit_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic [1:0]             fail_code_q, fail_code_d;

    logic [WIDTH-1:0]       exp_val;
    logic                   match;
    logic                   accept;
    logic                   timeout_hit;

    // Select the checkpoint value for the stage currently awaited
    always_comb begin
        exp_val = '0;
        for (int unsigned k = 0; k < NUM_CKPT; k++) begin
            if (stage_q == IDX_W'(k)) begin
                exp_val = cfg_ckpt[k*WIDTH +: WIDTH];
            end
        end
    end

    // Compare, stability-accept and timeout conditions for this cycle
    always_comb begin
        match       = (watch_in == exp_val);
        accept      = match && (match_cnt_q == MC_LAST);
        timeout_hit = (cfg_timeout != '0) && (timer_q == cfg_timeout - TIMEOUT_W'(1));
    end

    // Next-state and output logic; priority start > abort > accept > timeout
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        match_cnt_d = match_cnt_q;
        timer_d     = timer_q;
        busy_d      = busy_q;
        hit_d       = 1'b0;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_code_d = fail_code_q;

        if (start) begin
            state_d     = ST_ARMED;
            stage_d     = '0;
            match_cnt_d = '0;
            timer_d     = '0;
            busy_d      = 1'b1;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
            fail_code_d = CODE_NONE;
        end else if (state_q == ST_ARMED) begin
            if (abort) begin
                state_d     = ST_FAIL;
                busy_d      = 1'b0;
                fail_d      = 1'b1;
                fail_code_d = CODE_ABORT;
            end else if (accept) begin
                hit_d       = 1'b1;
                match_cnt_d = '0;
                timer_d     = '0;
                if (stage_q == IDX_LAST) begin
                    state_d = ST_PASS;
                    busy_d  = 1'b0;
                    pass_d  = 1'b1;
                end else begin
                    stage_d = stage_q + IDX_W'(1);
                end
            end else if (timeout_hit) begin
                state_d     = ST_FAIL;
                busy_d      = 1'b0;
                fail_d      = 1'b1;
                fail_code_d = CODE_TIMEOUT;
            end else begin
                if (!match) begin
                    match_cnt_d = '0;
                end else if (match_cnt_q != MC_LAST) begin
                    match_cnt_d = match_cnt_q + MC_W'(1);
                end
                // With no timeout programmed the timer parks at all-ones
                if (timer_q != '1) begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
            end
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            match_cnt_q <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            hit_q       <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= CODE_NONE;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            match_cnt_q <= match_cnt_d;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            hit_q       <= hit_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign busy      = busy_q;
    assign hit       = hit_q;
    assign stage     = stage_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Directed self-checking bench for mprj_checkpoint_monitor.
// dut_a: two checkpoints AB60 then AB61; dut_b: three repeated 0005 checkpoints.
module tb_mprj_checkpoint_monitor;

    logic        clock = 1'b0;
    logic        resetb;

    logic        start_a, abort_a;
    logic [31:0] cfg_ckpt_a;
    logic [23:0] cfg_timeout_a;
    logic [15:0] watch_a;
    logic        busy_a, hit_a, pass_a, fail_a;
    logic [0:0]  stage_a;
    logic [1:0]  code_a;

    logic        start_b, abort_b;
    logic [47:0] cfg_ckpt_b;
    logic [23:0] cfg_timeout_b;
    logic [15:0] watch_b;
    logic        busy_b, hit_b, pass_b, fail_b;
    logic [1:0]  stage_b;
    logic [1:0]  code_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mprj_checkpoint_monitor #(
        .WIDTH(16), .NUM_CKPT(2), .STABLE(2), .TIMEOUT_W(24)
    ) dut_a (
        .clock(clock), .resetb(resetb), .start(start_a), .abort(abort_a),
        .cfg_ckpt(cfg_ckpt_a), .cfg_timeout(cfg_timeout_a), .watch_in(watch_a),
        .busy(busy_a), .hit(hit_a), .stage(stage_a), .pass(pass_a),
        .fail(fail_a), .fail_code(code_a)
    );

    mprj_checkpoint_monitor #(
        .WIDTH(16), .NUM_CKPT(3), .STABLE(2), .TIMEOUT_W(24)
    ) dut_b (
        .clock(clock), .resetb(resetb), .start(start_b), .abort(abort_b),
        .cfg_ckpt(cfg_ckpt_b), .cfg_timeout(cfg_timeout_b), .watch_in(watch_b),
        .busy(busy_b), .hit(hit_b), .stage(stage_b), .pass(pass_b),
        .fail(fail_b), .fail_code(code_b)
    );

    // Count one comparison and report it on mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm_a(input logic [23:0] tmo);
        cfg_timeout_a = tmo;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Nominal two-checkpoint run ending in PASS
    task automatic nominal_a(input string pfx);
        arm_a(24'd1000);
        check({pfx, "_arm_busy"}, busy_a, 1);
        check({pfx, "_arm_stage"}, stage_a, 0);
        watch_a = 16'hAB60;
        tick();
        check({pfx, "_hit_early"}, hit_a, 0);
        tick();
        check({pfx, "_hit0"}, hit_a, 1);
        check({pfx, "_stage1"}, stage_a, 1);
        tick();
        check({pfx, "_nohit_extra"}, hit_a, 0);
        watch_a = 16'hAB61;
        tick();
        check({pfx, "_hit1_early"}, hit_a, 0);
        tick();
        check({pfx, "_hit1"}, hit_a, 1);
        check({pfx, "_pass"}, pass_a, 1);
        check({pfx, "_fail"}, fail_a, 0);
        check({pfx, "_busy_drop"}, busy_a, 0);
        check({pfx, "_stage_hold"}, stage_a, 1);
        tick();
        check({pfx, "_hit_pulse"}, hit_a, 0);
        check({pfx, "_pass_sticky"}, pass_a, 1);
    endtask

    initial begin
        resetb = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; watch_a = 16'h0000;
        cfg_ckpt_a = {16'hAB61, 16'hAB60}; cfg_timeout_a = 24'd1000;
        start_b = 1'b0; abort_b = 1'b0; watch_b = 16'h0000;
        cfg_ckpt_b = {16'h0005, 16'h0005, 16'h0005}; cfg_timeout_b = 24'd1000;
        tick();
        tick();
        check("rst_busy", busy_a, 0);
        check("rst_hit", hit_a, 0);
        check("rst_stage", stage_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_fail", fail_a, 0);
        check("rst_code", code_a, 0);
        resetb = 1'b1;

        // abort while IDLE has no effect
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("idle_abort_fail", fail_a, 0);
        check("idle_abort_code", code_a, 0);
        check("idle_abort_busy", busy_a, 0);

        nominal_a("nom");

        // Glitch rejection: single-cycle AB60 must not be accepted
        watch_a = 16'h0000;
        arm_a(24'd1000);
        check("gl_pass_clr", pass_a, 0);
        watch_a = 16'hAB60;
        tick();
        check("gl_hit_a", hit_a, 0);
        watch_a = 16'h0000;
        tick();
        check("gl_hit_b", hit_a, 0);
        watch_a = 16'hAB60;
        tick();
        check("gl_hit_c", hit_a, 0);
        check("gl_stage_c", stage_a, 0);
        tick();
        check("gl_hit_d", hit_a, 1);
        check("gl_stage_d", stage_a, 1);

        // Timeout of 8 cycles with the bus held at zero
        watch_a = 16'h0000;
        arm_a(24'd8);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("to_nofail_early", fail_a, 0);
        end
        tick();
        check("to_fail", fail_a, 1);
        check("to_code", code_a, 2'b01);
        check("to_pass", pass_a, 0);
        check("to_busy", busy_a, 0);

        // No timeout programmed: stays armed indefinitely
        arm_a(24'd0);
        check("nt_code_clr", code_a, 0);
        for (int i = 0; i < 10000; i++) tick();
        check("nt_fail", fail_a, 0);
        check("nt_busy", busy_a, 1);

        // Accept on the same edge as timeout wins
        arm_a(24'd2);
        watch_a = 16'hAB60;
        tick();
        check("sim_fail_a", fail_a, 0);
        tick();
        check("sim_hit", hit_a, 1);
        check("sim_fail", fail_a, 0);
        check("sim_stage", stage_a, 1);
        tick();
        check("sim2_fail_early", fail_a, 0);
        tick();
        check("sim2_fail", fail_a, 1);
        check("sim2_code", code_a, 2'b01);

        // start together with abort while ARMED re-arms
        arm_a(24'd1000);
        tick();
        tick();
        check("sa_stage1", stage_a, 1);
        start_a = 1'b1; abort_a = 1'b1;
        tick();
        start_a = 1'b0; abort_a = 1'b0;
        check("sa_stage0", stage_a, 0);
        check("sa_fail", fail_a, 0);
        check("sa_busy", busy_a, 1);
        watch_a = 16'h0000;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("ab_fail", fail_a, 1);
        check("ab_code", code_a, 2'b10);
        check("ab_busy", busy_a, 0);

        // Reset mid-operation at stage 1
        arm_a(24'd1000);
        watch_a = 16'hAB60;
        tick();
        tick();
        check("mr_stage1", stage_a, 1);
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        check("mr_busy", busy_a, 0);
        check("mr_hit", hit_a, 0);
        check("mr_stage", stage_a, 0);
        check("mr_fail", fail_a, 0);
        check("mr_code", code_a, 0);
        watch_a = 16'h0000;
        nominal_a("rerun");

        // Repeated checkpoints: three 0005 values with a held bus
        watch_b = 16'h0005;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("rp_busy", busy_b, 1);
        tick();
        check("rp_h1", hit_b, 0);
        tick();
        check("rp_h2", hit_b, 1);
        check("rp_s2", stage_b, 1);
        tick();
        check("rp_h3", hit_b, 0);
        tick();
        check("rp_h4", hit_b, 1);
        check("rp_s4", stage_b, 2);
        tick();
        check("rp_h5", hit_b, 0);
        check("rp_p5", pass_b, 0);
        tick();
        check("rp_h6", hit_b, 1);
        check("rp_pass", pass_b, 1);
        check("rp_busy_drop", busy_b, 0);
        check("rp_stage", stage_b, 2);
        check("rp_fail", fail_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
